morse_tx_scheduler: RTL and testbench

MORSE_TX_SCHEDULER -- requirements
Module: morse_tx_scheduler

---
 rtl/morse_pkg.sv | 36 +++
 rtl/morse_sym_fifo.sv | 51 +++++
 rtl/morse_tx_scheduler.sv | 136 +++++++++++++
 tb/tb_morse_tx_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse transmit scheduler.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_ELEM_GAP,
    ST_CHAR_GAP,
    ST_WORD_GAP
  } state_t;

  localparam int unsigned DIT_UNITS      = 1;
  localparam int unsigned DAH_UNITS      = 3;
  localparam int unsigned ELEM_GAP_UNITS = 1;
  localparam int unsigned CHAR_GAP_UNITS = 3;
  localparam int unsigned WORD_GAP_UNITS = 7;
  localparam int unsigned MAX_ELEMS      = 6;

  // Unit counter holds (units - 1) of the longest interval, the word gap.
  localparam int unsigned UNIT_CNT_W = $clog2(WORD_GAP_UNITS);

  typedef struct packed {
    logic [2:0] len;
    logic [5:0] pattern;
  } sym_t;

  // Length code 7 is sent as a full six-element symbol.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len == 3'd7) ? 3'(MAX_ELEMS) : len;
  endfunction

  function automatic logic [UNIT_CNT_W-1:0] mark_units(input logic is_dah);
    return is_dah ? UNIT_CNT_W'(DAH_UNITS - 1) : UNIT_CNT_W'(DIT_UNITS - 1);
  endfunction

endpackage

// File: rtl/morse_sym_fifo.sv
// Symbol queue: simultaneous push and pop both succeed even when full.
module morse_sym_fifo
  import morse_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  sym_t wr_data,
  output sym_t head,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sym_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array, no reset needed: contents are only read when occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/morse_tx_scheduler.sv
// Morse keying scheduler: pops queued symbols and times marks and gaps in units of UNIT_CYCLES.
module morse_tx_scheduler
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic [5:0] sym_pattern,
  input  logic [2:0] sym_len,
  output logic       dit_out,
  output logic       dah_out,
  output logic       key_out,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned PRESC_W = $clog2(UNIT_CYCLES);

  state_t                state, state_n;
  logic [PRESC_W-1:0]    presc, presc_n;
  logic [UNIT_CNT_W-1:0] units, units_n;
  logic [5:0]            shreg, shreg_n;
  logic [2:0]            elems, elems_n;
  logic                  pop;
  logic                  empty;
  logic                  dit_n, dah_n;
  sym_t                  wr_sym, head;

  assign wr_sym = {sym_len, sym_pattern};
  assign busy   = (state != ST_IDLE) || !empty;

  morse_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (sym_valid),
    .pop     (pop),
    .wr_data (wr_sym),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // Next-state, interval timing and element sequencing.
  always_comb begin
    state_n = state;
    presc_n = presc;
    units_n = units;
    shreg_n = shreg;
    elems_n = elems;
    pop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          presc_n = PRESC_W'(UNIT_CYCLES - 1);
          if (head.len == 3'd0) begin
            state_n = ST_WORD_GAP;
            units_n = UNIT_CNT_W'(WORD_GAP_UNITS - 1);
          end else begin
            state_n = ST_MARK;
            shreg_n = head.pattern;
            elems_n = clamp_len(head.len);
            units_n = mark_units(head.pattern[0]);
          end
        end
      end
      ST_MARK, ST_ELEM_GAP, ST_CHAR_GAP, ST_WORD_GAP: begin
        if (presc != '0) begin
          presc_n = presc - PRESC_W'(1);
        end else if (units != '0) begin
          units_n = units - UNIT_CNT_W'(1);
          presc_n = PRESC_W'(UNIT_CYCLES - 1);
        end else begin
          // Interval finished: reload the prescaler for whichever state comes next.
          presc_n = PRESC_W'(UNIT_CYCLES - 1);
          unique case (state)
            ST_MARK: begin
              if (elems > 3'd1) begin
                state_n = ST_ELEM_GAP;
                units_n = UNIT_CNT_W'(ELEM_GAP_UNITS - 1);
                shreg_n = shreg >> 1;
                elems_n = elems - 3'd1;
              end else begin
                state_n = ST_CHAR_GAP;
                units_n = UNIT_CNT_W'(CHAR_GAP_UNITS - 1);
              end
            end
            ST_ELEM_GAP: begin
              state_n = ST_MARK;
              units_n = mark_units(shreg[0]);
            end
            default: begin
              state_n = ST_IDLE;
              presc_n = '0;
              units_n = '0;
            end
          endcase
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Keying outputs are registered from the next state so they track MARK exactly.
    dit_n = (state_n == ST_MARK) && !shreg_n[0];
    dah_n = (state_n == ST_MARK) &&  shreg_n[0];
  end

  // State, counters and registered key outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      presc    <= '0;
      units    <= '0;
      shreg    <= '0;
      elems    <= '0;
      dit_out  <= 1'b0;
      dah_out  <= 1'b0;
      key_out  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      units   <= units_n;
      shreg   <= shreg_n;
      elems   <= elems_n;
      dit_out <= dit_n;
      dah_out <= dah_n;
      key_out <= dit_n | dah_n;
      if (sym_valid && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Self-checking bench for morse_tx_scheduler with a timeline-based reference model.
module tb_morse_tx_scheduler;

  localparam int U = 4;

  logic       clk;
  logic       rst_n;
  logic       sym_valid;
  logic [5:0] sym_pattern;
  logic [2:0] sym_len;
  logic       dit_out, dah_out, key_out, full, busy, overflow;

  int total = 0;
  int bad   = 0;

  int         len_a [6];
  logic [5:0] pat_a [6];

  morse_tx_scheduler #(.UNIT_CYCLES(U), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sym_valid   (sym_valid),
    .sym_pattern (sym_pattern),
    .sym_len     (sym_len),
    .dit_out     (dit_out),
    .dah_out     (dah_out),
    .key_out     (key_out),
    .full        (full),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic test_reset();
    logic [5:0] got;
    rst_n = 1'b0; sym_valid = 1'b0; sym_len = '0; sym_pattern = '0;
    repeat (3) @(negedge clk);
    got = {dit_out, dah_out, key_out, full, busy, overflow};
    total++;
    if (got !== 6'b0) begin bad++; $display("FAIL reset_hold: got %b want %b", got, 6'b0); end
    rst_n = 1'b1;
    @(negedge clk);
    got = {dit_out, dah_out, key_out, full, busy, overflow};
    total++;
    if (got !== 6'b0) begin bad++; $display("FAIL reset_release: got %b want %b", got, 6'b0); end
  endtask

  // Writes len_a/pat_a[0..n-1] back-to-back from idle and checks every cycle
  // against a timeline built from unit durations. Only five fit (4 queued + 1 popped).
  task automatic run_burst(input int n, input string tag);
    int         exp_q[$];
    int         acc, l, mu, code;
    logic [3:0] got, want;
    acc = (n > 5) ? 5 : n;
    for (int k = 0; k < acc; k++) begin
      exp_q.push_back(0);
      l = (len_a[k] == 7) ? 6 : len_a[k];
      if (l == 0) begin
        for (int j = 0; j < 7*U; j++) exp_q.push_back(0);
      end else begin
        for (int e = 0; e < l; e++) begin
          mu = pat_a[k][e] ? 3 : 1;
          code = pat_a[k][e] ? 2 : 1;
          for (int j = 0; j < mu*U; j++) exp_q.push_back(code);
          if (e < l-1) for (int j = 0; j < U; j++) exp_q.push_back(0);
        end
        for (int j = 0; j < 3*U; j++) exp_q.push_back(0);
      end
    end
    @(negedge clk);
    sym_valid = 1'b1; sym_len = 3'(len_a[0]); sym_pattern = pat_a[0];
    for (int i = 1; i <= exp_q.size(); i++) begin
      @(negedge clk);
      code = exp_q[i-1];
      want = {code == 1, code == 2, code != 0, 1'b1};
      got  = {dit_out, dah_out, key_out, busy};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s cyc%0d: got dit/dah/key/busy=%b want %b", tag, i, got, want);
      end
      if (n == 6 && i == 5) begin
        total++;
        if (full !== 1'b1) begin bad++; $display("FAIL %s full: got %b want 1", tag, full); end
      end
      if (i < n) begin
        sym_len = 3'(len_a[i]); sym_pattern = pat_a[i];
      end else begin
        sym_valid = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {dit_out, dah_out, key_out, busy};
      total++;
      if (got !== 4'b0) begin bad++; $display("FAIL %s idle: got %b want 0000", tag, got); end
    end
    if (n == 6) begin
      total++;
      if (overflow !== 1'b1) begin bad++; $display("FAIL %s overflow: got %b want 1", tag, overflow); end
    end
  endtask

  task automatic test_letter_e();
    len_a[0] = 1; pat_a[0] = 6'b000000;
    run_burst(1, "letter_e");
  endtask

  task automatic test_letter_a();
    len_a[0] = 2; pat_a[0] = 6'b000010;
    run_burst(1, "letter_a");
  endtask

  task automatic test_word_space();
    len_a[0] = 0; pat_a[0] = 6'b101010;
    run_burst(1, "word_space");
  endtask

  task automatic test_len7();
    len_a[0] = 7; pat_a[0] = 6'b110101;
    run_burst(1, "len7");
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < 6; k++) begin
        len_a[k] = $urandom_range(0, 7);
        pat_a[k] = 6'($urandom);
      end
      run_burst(n, "random");
    end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL random_no_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 6; k++) begin
      len_a[k] = $urandom_range(1, 3);
      pat_a[k] = 6'($urandom);
    end
    run_burst(6, "overflow");
    repeat (5) @(negedge clk);
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid_dah();
    logic [5:0] got;
    @(negedge clk);
    sym_valid = 1'b1; sym_len = 3'd1; sym_pattern = 6'b000001;
    @(negedge clk);
    sym_len = 3'd2; sym_pattern = 6'b000011;
    @(negedge clk);
    sym_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (dah_out !== 1'b1) begin bad++; $display("FAIL mid_dah_pre: got %b want 1", dah_out); end
    #1 rst_n = 1'b0;
    #1;
    got = {dit_out, dah_out, key_out, full, busy, overflow};
    total++;
    if (got !== 6'b0) begin bad++; $display("FAIL mid_dah_async: got %b want %b", got, 6'b0); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      got = {dit_out, dah_out, key_out, full, busy, overflow};
      total++;
      if (got !== 6'b0) begin bad++; $display("FAIL mid_dah_after cyc%0d: got %b want %b", i, got, 6'b0); end
    end
  endtask

  initial begin
    test_reset();
    test_letter_e();
    test_letter_a();
    test_word_space();
    test_len7();
    test_random();
    test_overflow();
    test_reset_mid_dah();
    test_letter_e();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
